// File: rtl/fram_arbiter_if.sv
// rtl/fram_arbiter_if.sv - req/gnt/rvalid requester port of the FRAM arbiter
interface fram_arbiter_if #(
    parameter int ADDR_BITS = 12
);
    logic                 req;
    logic                 we;
    logic [3:0]           be;
    logic [ADDR_BITS-1:0] addr;
    logic [31:0]          wdata;
    logic                 gnt;
    logic                 rvalid;
    logic [31:0]          rdata;
    logic                 err;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/fram_arbiter.sv
// rtl/fram_arbiter.sv - round-robin arbiter sharing one FRAM port between CPU (A) and zeroization engine (B)
module fram_arbiter #(
    parameter int ADDR_BITS    = 12,
    parameter int WRITE_CYCLES = 3,
    parameter int PROT_WORDS   = 256
) (
    input  logic                 clk,
    input  logic                 resetn,
    fram_arbiter_if.slave        a,
    fram_arbiter_if.slave        b,
    input  logic                 lock,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [3:0]           mem_be,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam int CW = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;
    localparam logic [CW-1:0]      CNT_INIT = CW'(WRITE_CYCLES - 1);
    localparam logic [ADDR_BITS:0] PROT_LIM = (ADDR_BITS + 1)'(PROT_WORDS);

    logic [1:0]    state;
    logic [CW-1:0] count;
    logic          owner;       // 0 = port A, 1 = port B
    logic          last_owner;

    logic                 any_req;
    logic                 win_b;
    logic                 grant;
    logic                 prot;
    logic                 sel_we;
    logic [3:0]           sel_be;
    logic [ADDR_BITS-1:0] sel_addr;
    logic [31:0]          sel_wdata;
    logic                 rd_done;
    logic                 wr_done;
    logic                 err_done;

    always_comb begin
        any_req   = a.req | b.req;
        // on a tie the port that did not own the previous grant wins
        win_b     = b.req & (~a.req | ~last_owner);
        grant     = resetn & (state == S_IDLE) & any_req;
        sel_we    = win_b ? b.we    : a.we;
        sel_be    = win_b ? b.be    : a.be;
        sel_addr  = win_b ? b.addr  : a.addr;
        sel_wdata = win_b ? b.wdata : a.wdata;
        prot      = ~win_b & a.we & lock & ({1'b0, a.addr} < PROT_LIM);

        a.gnt     = grant & ~win_b;
        b.gnt     = grant & win_b;

        // a protected write is granted and answered with err, but never reaches FRAM
        mem_en    = grant & ~prot;
        mem_we    = mem_en & sel_we;
        mem_be    = mem_en ? sel_be    : 4'd0;
        mem_addr  = mem_en ? sel_addr  : '0;
        mem_wdata = mem_en ? sel_wdata : 32'd0;

        rd_done   = (state == S_RD);
        wr_done   = (state == S_WR) && (count == '0);
        err_done  = (state == S_ERR);

        a.rvalid  = ((rd_done | wr_done) & ~owner) | err_done;
        a.rdata   = (rd_done & ~owner) ? mem_rdata : 32'd0;
        a.err     = err_done;
        b.rvalid  = (rd_done | wr_done) & owner;
        b.rdata   = (rd_done & owner) ? mem_rdata : 32'd0;
        b.err     = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            count      <= '0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        owner      <= win_b;
                        last_owner <= win_b;
                        count      <= CNT_INIT;
                        if (prot)
                            state <= S_ERR;
                        else if (sel_we)
                            state <= S_WR;
                        else
                            state <= S_RD;
                    end
                end
                S_WR: begin
                    if (count != '0)
                        count <= count - CW'(1);
                    else
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
